// File: rtl/exc_pkg.sv
// Shared types and encodings for the LEGv8 exception controller.
package exc_pkg;

   localparam int unsigned ESR_W   = 4;
   localparam int unsigned PCSEL_W = 2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FLUSH   = 3'd1,
      S_VECTOR  = 3'd2,
      S_HANDLER = 3'd3,
      S_RETURN  = 3'd4,
      S_HALT    = 3'd5
   } state_t;

   // ESR cause codes (one-hot)
   localparam logic [ESR_W-1:0] ESR_NONE = 4'b0000;
   localparam logic [ESR_W-1:0] ESR_IRQ  = 4'b0001;
   localparam logic [ESR_W-1:0] ESR_INV  = 4'b0010;
   localparam logic [ESR_W-1:0] ESR_BR   = 4'b0100;
   localparam logic [ESR_W-1:0] ESR_DBL  = 4'b1000;

   // Fetch-stage PC-select encodings
   localparam logic [PCSEL_W-1:0] PC_SEQ = 2'b00;
   localparam logic [PCSEL_W-1:0] PC_VEC = 2'b01;
   localparam logic [PCSEL_W-1:0] PC_RET = 2'b10;

   // Cause selection while idle. ERET outside a handler is an illegal instruction.
   // The interrupt is a level and is taken even when ID holds a bubble.
   function automatic logic [ESR_W-1:0] idle_cause(input logic valid,
                                                   input logic not_an_instr,
                                                   input logic incon_branch,
                                                   input logic eret,
                                                   input logic ext_irq);
      logic [ESR_W-1:0] cause;
      cause = ESR_NONE;
      if (valid && not_an_instr)      cause = ESR_INV;
      else if (valid && incon_branch) cause = ESR_BR;
      else if (valid && eret)         cause = ESR_INV;
      else if (ext_irq)               cause = ESR_IRQ;
      return cause;
   endfunction

endpackage

// File: rtl/exc_regs.sv
// Exception link (ELR) and syndrome (ESR) registers with independent load enables.
// Ports: clk, reset (async, active-high), elr_we_i/elr_d_i, esr_we_i/esr_d_i -> elr_o, esr_o.
module exc_regs
   import exc_pkg::*;
#(
   parameter int unsigned N = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             elr_we_i,
   input  logic [N-1:0]     elr_d_i,
   input  logic             esr_we_i,
   input  logic [ESR_W-1:0] esr_d_i,
   output logic [N-1:0]     elr_o,
   output logic [ESR_W-1:0] esr_o
);

   logic [N-1:0]     elr_q;
   logic [ESR_W-1:0] esr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         elr_q <= '0;
         esr_q <= '0;
      end else begin
         if (elr_we_i) elr_q <= elr_d_i;
         if (esr_we_i) esr_q <= esr_d_i;
      end
   end

   assign elr_o = elr_q;
   assign esr_o = esr_q;

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: sequences entry (flush, vector, handler) and ERET return,
// owns ELR/ESR and drives the fetch PC-select mux. Outputs are Moore decodes of
// registered state only.
// Ports: clk, reset; Valid_i, PC_i, NotAnInstr, InconBranch, ERet, ExtIRQ from ID;
//        ExtIAck, Flush, PCSel, Exc_PC, ELR, ESR, InHandler out.
module exception_ctrl
   import exc_pkg::*;
#(
   parameter int unsigned   N           = 64,
   parameter logic [N-1:0]  VECTOR_ADDR = N'(64'hD8)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Valid_i,
   input  logic [N-1:0]       PC_i,
   input  logic               NotAnInstr,
   input  logic               InconBranch,
   input  logic               ERet,
   input  logic               ExtIRQ,
   output logic               ExtIAck,
   output logic               Flush,
   output logic [PCSEL_W-1:0] PCSel,
   output logic [N-1:0]       Exc_PC,
   output logic [N-1:0]       ELR,
   output logic [ESR_W-1:0]   ESR,
   output logic               InHandler
);

   state_t           state_q, state_d;
   logic             elr_we, esr_we;
   logic [ESR_W-1:0] esr_d;
   logic [ESR_W-1:0] cause_c;

   assign cause_c = idle_cause(Valid_i, NotAnInstr, InconBranch, ERet, ExtIRQ);

   exc_regs #(.N(N)) u_regs (
      .clk      (clk),
      .reset    (reset),
      .elr_we_i (elr_we),
      .elr_d_i  (PC_i),
      .esr_we_i (esr_we),
      .esr_d_i  (esr_d),
      .elr_o    (ELR),
      .esr_o    (ESR)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state, register loads and output decode
   always_comb begin
      state_d   = state_q;
      elr_we    = 1'b0;
      esr_we    = 1'b0;
      esr_d     = ESR_NONE;
      Flush     = 1'b0;
      PCSel     = PC_SEQ;
      Exc_PC    = '0;
      ExtIAck   = 1'b0;
      InHandler = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cause_c != ESR_NONE) begin
               elr_we  = 1'b1;
               esr_we  = 1'b1;
               esr_d   = cause_c;
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            Flush   = 1'b1;
            state_d = S_VECTOR;
         end
         S_VECTOR: begin
            PCSel   = PC_VEC;
            Exc_PC  = VECTOR_ADDR;
            ExtIAck = (ESR == ESR_IRQ);
            state_d = S_HANDLER;
         end
         S_HANDLER: begin
            // Interrupts are masked here; only ERET or a nested fault leaves.
            InHandler = 1'b1;
            if (Valid_i && ERet) begin
               state_d = S_RETURN;
            end else if (Valid_i && (NotAnInstr || InconBranch)) begin
               esr_we  = 1'b1;
               esr_d   = ESR_DBL;
               state_d = S_HALT;
            end
         end
         S_RETURN: begin
            PCSel   = PC_RET;
            Exc_PC  = ELR;
            Flush   = 1'b1;
            state_d = S_IDLE;
         end
         S_HALT: begin
            // Double fault: hold the pipeline squashed until reset.
            Flush = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: each scenario queues per-cycle stimulus and
// the expected output vector, then replays and compares cycle by cycle.
module tb_exception_ctrl;

   localparam logic [63:0] VEC = 64'hD8;

   typedef struct packed {
      logic        v;
      logic [63:0] pc;
      logic        nai;
      logic        ib;
      logic        er;
      logic        irq;
   } stim_t;

   // {Flush, PCSel, Exc_PC, ELR, ESR, ExtIAck, InHandler}
   typedef logic [136:0] ovec_t;

   logic        clk;
   logic        reset;
   logic        Valid_i;
   logic [63:0] PC_i;
   logic        NotAnInstr, InconBranch, ERet, ExtIRQ;
   logic        ExtIAck, Flush, InHandler;
   logic [1:0]  PCSel;
   logic [63:0] Exc_PC, ELR;
   logic [3:0]  ESR;

   int n_checks = 0;
   int n_fail   = 0;

   exception_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .Valid_i     (Valid_i),
      .PC_i        (PC_i),
      .NotAnInstr  (NotAnInstr),
      .InconBranch (InconBranch),
      .ERet        (ERet),
      .ExtIRQ      (ExtIRQ),
      .ExtIAck     (ExtIAck),
      .Flush       (Flush),
      .PCSel       (PCSel),
      .Exc_PC      (Exc_PC),
      .ELR         (ELR),
      .ESR         (ESR),
      .InHandler   (InHandler)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t st(input logic v, input logic [63:0] pc, input logic nai,
                                input logic ib, input logic er, input logic irq);
      return '{v: v, pc: pc, nai: nai, ib: ib, er: er, irq: irq};
   endfunction

   function automatic ovec_t mk(input logic f, input logic [1:0] ps, input logic [63:0] xpc,
                                input logic [63:0] elr, input logic [3:0] esr,
                                input logic ack, input logic inh);
      return {f, ps, xpc, elr, esr, ack, inh};
   endfunction

   function automatic ovec_t cur();
      return {Flush, PCSel, Exc_PC, ELR, ESR, ExtIAck, InHandler};
   endfunction

   task automatic test_reset();
      ovec_t o;
      reset = 1'b1;
      {Valid_i, PC_i, NotAnInstr, InconBranch, ERet, ExtIRQ} = '0;
      #12;
      o = cur();
      n_checks++;
      if (o !== '0) begin
         n_fail++;
         $display("FAIL reset_asserted: got %h expected 0", o);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      o = cur();
      n_checks++;
      if (o !== '0) begin
         n_fail++;
         $display("FAIL reset_released_idle: got %h expected 0", o);
      end
   endtask

   task automatic test_invalid_opcode();
      stim_t sq[$];
      ovec_t eq[$];
      stim_t s;
      ovec_t e, o;
      int k = 0;
      sq.push_back(st(1, 64'h40, 1, 0, 0, 0)); eq.push_back(mk(1, 2'b00, 0,    64'h40, 4'b0010, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));      eq.push_back(mk(0, 2'b01, VEC,  64'h40, 4'b0010, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));      eq.push_back(mk(0, 2'b00, 0,    64'h40, 4'b0010, 0, 1));
      sq.push_back(st(0, 0, 0, 0, 0, 0));      eq.push_back(mk(0, 2'b00, 0,    64'h40, 4'b0010, 0, 1));
      sq.push_back(st(1, 64'h44, 0, 0, 1, 0)); eq.push_back(mk(1, 2'b10, 64'h40, 64'h40, 4'b0010, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));      eq.push_back(mk(0, 2'b00, 0,    64'h40, 4'b0010, 0, 0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         {Valid_i, PC_i, NotAnInstr, InconBranch, ERet, ExtIRQ} = s;
         @(posedge clk); #1;
         e = eq.pop_front();
         o = cur();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL invalid_opcode step %0d: got %h expected %h", k, o, e);
         end
         k++;
      end
   endtask

   task automatic test_irq();
      stim_t sq[$];
      ovec_t eq[$];
      stim_t s;
      ovec_t e, o;
      int k = 0;
      sq.push_back(st(0, 64'h100, 0, 0, 0, 1)); eq.push_back(mk(1, 2'b00, 0,      64'h100, 4'b0001, 0, 0));
      sq.push_back(st(0, 64'h104, 0, 0, 0, 1)); eq.push_back(mk(0, 2'b01, VEC,    64'h100, 4'b0001, 1, 0));
      sq.push_back(st(0, 64'h108, 0, 0, 0, 1)); eq.push_back(mk(0, 2'b00, 0,      64'h100, 4'b0001, 0, 1));
      sq.push_back(st(1, 64'h10C, 0, 0, 0, 1)); eq.push_back(mk(0, 2'b00, 0,      64'h100, 4'b0001, 0, 1));
      sq.push_back(st(1, 64'h200, 0, 0, 1, 1)); eq.push_back(mk(1, 2'b10, 64'h100, 64'h100, 4'b0001, 0, 0));
      sq.push_back(st(0, 64'h300, 0, 0, 0, 1)); eq.push_back(mk(0, 2'b00, 0,      64'h100, 4'b0001, 0, 0));
      sq.push_back(st(0, 64'h300, 0, 0, 0, 1)); eq.push_back(mk(1, 2'b00, 0,      64'h300, 4'b0001, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));       eq.push_back(mk(0, 2'b01, VEC,    64'h300, 4'b0001, 1, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));       eq.push_back(mk(0, 2'b00, 0,      64'h300, 4'b0001, 0, 1));
      sq.push_back(st(1, 64'h310, 0, 0, 1, 0)); eq.push_back(mk(1, 2'b10, 64'h300, 64'h300, 4'b0001, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));       eq.push_back(mk(0, 2'b00, 0,      64'h300, 4'b0001, 0, 0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         {Valid_i, PC_i, NotAnInstr, InconBranch, ERet, ExtIRQ} = s;
         @(posedge clk); #1;
         e = eq.pop_front();
         o = cur();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL irq_entry_return step %0d: got %h expected %h", k, o, e);
         end
         k++;
      end
   endtask

   task automatic test_simultaneous();
      stim_t sq[$];
      ovec_t eq[$];
      stim_t s;
      ovec_t e, o;
      int k = 0;
      sq.push_back(st(1, 64'h80, 1, 0, 0, 1)); eq.push_back(mk(1, 2'b00, 0,     64'h80, 4'b0010, 0, 0));
      sq.push_back(st(0, 64'h84, 0, 0, 0, 1)); eq.push_back(mk(0, 2'b01, VEC,   64'h80, 4'b0010, 0, 0));
      sq.push_back(st(0, 64'h88, 0, 0, 0, 1)); eq.push_back(mk(0, 2'b00, 0,     64'h80, 4'b0010, 0, 1));
      sq.push_back(st(1, 64'h8C, 0, 0, 1, 1)); eq.push_back(mk(1, 2'b10, 64'h80, 64'h80, 4'b0010, 0, 0));
      sq.push_back(st(0, 64'h90, 0, 0, 0, 1)); eq.push_back(mk(0, 2'b00, 0,     64'h80, 4'b0010, 0, 0));
      sq.push_back(st(0, 64'h90, 0, 0, 0, 1)); eq.push_back(mk(1, 2'b00, 0,     64'h90, 4'b0001, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));      eq.push_back(mk(0, 2'b01, VEC,   64'h90, 4'b0001, 1, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));      eq.push_back(mk(0, 2'b00, 0,     64'h90, 4'b0001, 0, 1));
      sq.push_back(st(1, 64'h94, 0, 0, 1, 0)); eq.push_back(mk(1, 2'b10, 64'h90, 64'h90, 4'b0001, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));      eq.push_back(mk(0, 2'b00, 0,     64'h90, 4'b0001, 0, 0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         {Valid_i, PC_i, NotAnInstr, InconBranch, ERet, ExtIRQ} = s;
         @(posedge clk); #1;
         e = eq.pop_front();
         o = cur();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL sync_beats_irq step %0d: got %h expected %h", k, o, e);
         end
         k++;
      end
   endtask

   task automatic test_eret_idle();
      stim_t sq[$];
      ovec_t eq[$];
      stim_t s;
      ovec_t e, o;
      int k = 0;
      sq.push_back(st(1, 64'h20, 0, 0, 1, 0)); eq.push_back(mk(1, 2'b00, 0,     64'h20, 4'b0010, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));      eq.push_back(mk(0, 2'b01, VEC,   64'h20, 4'b0010, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));      eq.push_back(mk(0, 2'b00, 0,     64'h20, 4'b0010, 0, 1));
      sq.push_back(st(1, 64'h24, 0, 0, 1, 0)); eq.push_back(mk(1, 2'b10, 64'h20, 64'h20, 4'b0010, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));      eq.push_back(mk(0, 2'b00, 0,     64'h20, 4'b0010, 0, 0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         {Valid_i, PC_i, NotAnInstr, InconBranch, ERet, ExtIRQ} = s;
         @(posedge clk); #1;
         e = eq.pop_front();
         o = cur();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL eret_in_idle step %0d: got %h expected %h", k, o, e);
         end
         k++;
      end
   endtask

   task automatic test_double_fault();
      stim_t sq[$];
      ovec_t eq[$];
      stim_t s;
      ovec_t e, o;
      int k = 0;
      sq.push_back(st(1, 64'h60, 0, 1, 0, 0)); eq.push_back(mk(1, 2'b00, 0,   64'h60, 4'b0100, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));      eq.push_back(mk(0, 2'b01, VEC, 64'h60, 4'b0100, 0, 0));
      sq.push_back(st(0, 0, 0, 0, 0, 0));      eq.push_back(mk(0, 2'b00, 0,   64'h60, 4'b0100, 0, 1));
      sq.push_back(st(1, 64'h70, 0, 1, 0, 0)); eq.push_back(mk(1, 2'b00, 0,   64'h60, 4'b1000, 0, 0));
      for (int i = 0; i < 6; i++) begin
         sq.push_back(st(1'($urandom), 64'($urandom), 1'($urandom), 1'($urandom),
                         1'($urandom), 1'($urandom)));
         eq.push_back(mk(1, 2'b00, 0, 64'h60, 4'b1000, 0, 0));
      end
      while (sq.size() > 0) begin
         s = sq.pop_front();
         {Valid_i, PC_i, NotAnInstr, InconBranch, ERet, ExtIRQ} = s;
         @(posedge clk); #1;
         e = eq.pop_front();
         o = cur();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL double_fault_halt step %0d: got %h expected %h", k, o, e);
         end
         k++;
      end
      // Only reset leaves HALT
      {Valid_i, PC_i, NotAnInstr, InconBranch, ERet, ExtIRQ} = '0;
      #2 reset = 1'b1;
      #1;
      o = cur();
      n_checks++;
      if (o !== '0) begin
         n_fail++;
         $display("FAIL halt_reset: got %h expected 0", o);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset_mid_vector();
      ovec_t o, e;
      {Valid_i, PC_i, NotAnInstr, InconBranch, ERet, ExtIRQ} = {1'b1, 64'h40, 1'b1, 3'b000};
      @(posedge clk); #1;
      {Valid_i, PC_i, NotAnInstr, InconBranch, ERet, ExtIRQ} = '0;
      @(posedge clk); #1;
      e = mk(0, 2'b01, VEC, 64'h40, 4'b0010, 0, 0);
      o = cur();
      n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL reset_mid_vector_pre: got %h expected %h", o, e);
      end
      #2 reset = 1'b1;
      #1;
      o = cur();
      n_checks++;
      if (o !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_vector_async: got %h expected 0", o);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      o = cur();
      n_checks++;
      if (o !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_vector_idle: got %h expected 0", o);
      end
      // IRQ pulse that drops before the next sampling edge is ignored
      ExtIRQ = 1'b1;
      PC_i   = 64'h500;
      #2 ExtIRQ = 1'b0;
      @(posedge clk); #1;
      o = cur();
      n_checks++;
      if (o !== '0) begin
         n_fail++;
         $display("FAIL irq_glitch_ignored: got %h expected 0", o);
      end
   endtask

   initial begin
      test_reset();
      test_invalid_opcode();
      test_irq();
      test_simultaneous();
      test_eret_idle();
      test_double_fault();
      test_reset_mid_vector();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
